ram_stream_reader: RTL and testbench

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

---
 rtl/ram_stream_reader.sv | 152 +++++++++++++++
 tb/tb_ram_stream_reader.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ram_stream_reader.sv
// ram_stream_reader
// Reads a burst of consecutive words from a 1R1W RAM read port (one-cycle read
// latency) and presents them as a valid/ready stream.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   cmd_valid/ready command handshake; cmd_addr = start word, cmd_len = words (0 legal)
//   mem_r_addr      RAM read address (held when no read is issued)
//   mem_r_dout      RAM read data, valid one cycle after its address
//   out_valid/ready stream handshake; out_data word, out_last marks final word
//   busy            FSM not IDLE
//   done            one-cycle pulse on burst completion
//   dbg_state       current FSM state
//
// Handshake rule (both cmd and out): a transfer happens in a cycle where valid
// and ready are both 1 at the rising clock edge; valid never depends on ready.
module ram_stream_reader #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W:0]   cmd_len,
  output logic [ADDR_W-1:0] mem_r_addr,
  input  logic [DATA_W-1:0] mem_r_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   LEN_ONE  = 1;
  localparam logic [ADDR_W:0]   LEN_ZERO = '0;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W:0]     rem_q;
  logic [ADDR_W-1:0]   addr_hold_q;
  logic                inflight_q;
  logic                inflight_last_q;
  logic                done_q;
  logic [DATA_W-1:0]   fifo_data_q [2];
  logic                fifo_last_q [2];
  logic                wr_ptr_q;
  logic                rd_ptr_q;
  logic [1:0]          count_q;

  logic                accept;
  logic                issue;
  logic                push;
  logic                pop;
  logic                last_pop;
  logic [2:0]          occ;

  assign accept = (state_q == IDLE) && cmd_valid;
  assign push   = inflight_q;
  assign pop    = (count_q != 2'd0) && out_ready;

  // Slots that will be occupied after this edge if nothing new is issued:
  // stored words plus the word returning from the RAM, minus the word leaving.
  assign occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = (state_q == ISSUE) && (rem_q != LEN_ZERO) && (occ < 3'd2);

  assign last_pop = pop && fifo_last_q[rd_ptr_q];

  // Address is combinational during an issue so the RAM sees it this cycle.
  assign mem_r_addr = issue ? addr_q : addr_hold_q;

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign dbg_state = state_q;
  assign out_valid = (count_q != 2'd0);
  assign out_data  = fifo_data_q[rd_ptr_q];
  // Gated so a stale head entry never shows a last marker on an idle stream.
  assign out_last  = out_valid && fifo_last_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid && (cmd_len != LEN_ZERO)) state_d = ISSUE;
      ISSUE:   if (issue && (rem_q == LEN_ONE)) state_d = DRAIN;
      DRAIN:   if (last_pop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q          <= '0;
      rem_q           <= '0;
      addr_hold_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
    end else begin
      if (accept) begin
        addr_q <= cmd_addr;
        rem_q  <= cmd_len;
      end else if (issue) begin
        addr_q <= addr_q + ADDR_ONE;
        rem_q  <= rem_q - LEN_ONE;
      end

      if (issue) addr_hold_q <= addr_q;

      inflight_q      <= issue;
      inflight_last_q <= issue && (rem_q == LEN_ONE);

      done_q <= (accept && (cmd_len == LEN_ZERO)) || ((state_q == DRAIN) && last_pop);

      if (push) begin
        fifo_data_q[wr_ptr_q] <= mem_r_dout;
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;

      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader. The RAM model returns mem[a] = a with
// one cycle of read latency. Inputs are driven and outputs sampled on the
// falling clock edge.
module tb_ram_stream_reader;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [10:0] cmd_addr;
  logic [11:0] cmd_len;
  logic [10:0] mem_r_addr;
  logic [31:0] mem_r_dout;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  ram_stream_reader #(.ADDR_W(11), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .mem_r_addr (mem_r_addr),
    .mem_r_dout (mem_r_dout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // clock / RAM model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) mem_r_dout <= {21'd0, mem_r_addr};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issues one command at the current falling edge and follows it to done.
  // mode 0: out_ready always 1; mode 1: out_ready pattern 1,0,0 from first word.
  // hold: leave cmd_valid asserted for the whole burst.
  task automatic burst(input logic [10:0] addr, input logic [11:0] len,
                       input int mode, input bit hold);
    logic [10:0] a;
    logic [31:0] exp_d;
    logic [31:0] held;
    logic        exp_l;
    logic        stalled;
    bit          done_now;
    bit          done_next;
    bit          finished;
    int          first_k;
    exp_q.delete();
    for (int i = 0; i < int'(len); i++) begin
      a = addr + 11'(i);
      exp_q.push_back({21'd0, a});
    end
    chk("cmd_ready_at_cmd", 32'(cmd_ready), 32'd1);
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_valid = 1'b1;
    out_ready = 1'b1;
    done_next = (len == 12'd0);
    stalled   = 1'b0;
    held      = '0;
    first_k   = 0;
    finished  = 0;
    for (int k = 1; k <= 3000 && !finished; k++) begin
      @(negedge clk);
      if (!hold) cmd_valid = 1'b0;
      out_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
      done_now  = done_next;
      done_next = 0;
      chk("done", 32'(done), 32'(done_now));
      chk("busy", 32'(busy), 32'((len != 12'd0) && !done_now));
      chk("cmd_ready", 32'(cmd_ready), 32'((len == 12'd0) || done_now));
      if (len == 12'd0) chk("no_valid_len0", 32'(out_valid), 32'd0);
      if (stalled) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", out_data, held);
      end
      if (out_valid && first_k == 0) first_k = k;
      if (out_valid && out_ready) begin
        chk("word_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_l = (exp_q.size() == 1);
          exp_d = exp_q.pop_front();
          chk("data", out_data, exp_d);
          chk("last", 32'(out_last), 32'(exp_l));
          if (exp_l) done_next = 1;
        end
      end
      stalled = out_valid && !out_ready;
      held    = out_data;
      if (done_now) finished = 1;
    end
    chk("burst_timeout", 32'(finished), 32'd1);
    chk("words_left", 32'(exp_q.size()), 32'd0);
    // accept edge, issue cycle, RAM return cycle, then the word is in the FIFO
    if (mode == 0 && len != 12'd0) chk("first_valid_cycle", 32'(first_k), 32'd3);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_last"}, 32'(out_last), 32'd0);
    chk({tag, "_out_data"}, out_data, 32'd0);
    chk({tag, "_mem_r_addr"}, 32'(mem_r_addr), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  initial begin
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    burst(11'd5, 12'd4, 0, 0);       // 5,6,7,8 back to back
    burst(11'd5, 12'd4, 1, 0);       // same with sink stalls
    burst(11'd2046, 12'd4, 0, 0);    // 2046,2047,0,1
    burst(11'd5, 12'd0, 0, 0);       // empty burst
    burst(11'd9, 12'd3, 0, 1);       // cmd_valid held through burst
    burst(11'd9, 12'd3, 0, 0);       // accepted in the done cycle

    // abort after two words of a len=10 burst
    cmd_addr  = 11'd100;
    cmd_len   = 12'd10;
    cmd_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_second_word", out_data, 32'd101);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_no_valid", 32'(out_valid), 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("post_abort_done", 32'(done), 32'd0);
    chk("post_abort_busy", 32'(busy), 32'd0);
    chk("post_abort_valid", 32'(out_valid), 32'd0);
    burst(11'd300, 12'd5, 0, 0);

    burst(11'd7, 12'd2048, 0, 0);    // full-size burst, wraps once

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
